// File: rtl/frame_scheduler.sv
// Frame timing generator plus erase -> move -> draw sequencer for the stacker.
// Latency: frame_tick one cycle after the counter reaches zero; req outputs follow the state register.
// Backpressure: erase/draw reqs hold until their done; ticks arriving mid-sequence are dropped and counted.
module frame_scheduler #(
    parameter int CNT_W       = 32,
    parameter int BASE_PERIOD = 833332,
    parameter int STEP        = 50000,
    parameter int MIN_PERIOD  = 100000,
    parameter int LEVEL_W     = 4,
    parameter int MAX_LEVEL   = 15
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               enable,
    input  logic               level_up,
    input  logic               level_clr,
    input  logic               erase_done,
    input  logic               draw_done,
    output logic               frame_tick,
    output logic               erase_req,
    output logic               move_pulse,
    output logic               draw_req,
    output logic               busy,
    output logic [LEVEL_W-1:0] level,
    output logic [CNT_W-1:0]   period,
    output logic [7:0]         overrun_cnt
);

    // One extra bit beyond the product width so BASE - level*STEP can go negative.
    localparam int PW = CNT_W + LEVEL_W + 1;

    localparam logic signed [PW-1:0]  LP_BASE    = PW'(BASE_PERIOD);
    localparam logic signed [PW-1:0]  LP_STEP    = PW'(STEP);
    localparam logic signed [PW-1:0]  LP_MIN     = PW'(MIN_PERIOD);
    localparam logic [CNT_W-1:0]      LP_RST_CNT = CNT_W'(BASE_PERIOD);
    localparam logic [CNT_W-1:0]      LP_ONE     = CNT_W'(1);
    localparam logic [LEVEL_W-1:0]    LP_LVL_MAX = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0]    LP_LVL_ONE = LEVEL_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ERASE = 2'd1,
        S_MOVE  = 2'd2,
        S_DRAW  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_counter;
    logic [CNT_W-1:0]     r_period;
    logic [LEVEL_W-1:0]   r_level;
    logic                 r_frame_tick;
    logic [7:0]           r_overrun;

    logic signed [PW-1:0] w_level_ext;
    logic signed [PW-1:0] w_period_calc;
    logic [CNT_W-1:0]     w_period_nxt;
    logic                 w_erase_req;
    logic                 w_move_pulse;
    logic                 w_draw_req;
    logic                 w_busy;

    // Signed period arithmetic; an underflow lands below the floor and is clamped.
    assign w_level_ext   = {{(PW-LEVEL_W){1'b0}}, r_level};
    assign w_period_calc = LP_BASE - (w_level_ext * LP_STEP);
    assign w_period_nxt  = (w_period_calc < LP_MIN) ? LP_MIN[CNT_W-1:0]
                                                    : w_period_calc[CNT_W-1:0];

    // Level register: clear wins over increment, increment saturates.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_level <= '0;
        end else if (level_clr) begin
            r_level <= '0;
        end else if (level_up && (r_level < LP_LVL_MAX)) begin
            r_level <= r_level + LP_LVL_ONE;
        end
    end

    // Registered reload value, one cycle behind the level register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_period <= LP_RST_CNT;
        end else begin
            r_period <= w_period_nxt;
        end
    end

    // Frame divider: counts down while enabled, reloads and ticks at zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_counter    <= LP_RST_CNT;
            r_frame_tick <= 1'b0;
        end else if (enable) begin
            if (r_counter == '0) begin
                r_counter    <= r_period;
                r_frame_tick <= 1'b1;
            end else begin
                r_counter    <= r_counter - LP_ONE;
                r_frame_tick <= 1'b0;
            end
        end else begin
            r_frame_tick <= 1'b0;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequencer next state and Moore outputs; done inputs only matter in their own state.
    always_comb begin
        w_state_nxt  = r_state;
        w_erase_req  = 1'b0;
        w_move_pulse = 1'b0;
        w_draw_req   = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (r_frame_tick) begin
                    w_state_nxt = S_ERASE;
                end
            end
            S_ERASE: begin
                w_erase_req = 1'b1;
                if (erase_done) begin
                    w_state_nxt = S_MOVE;
                end
            end
            S_MOVE: begin
                w_move_pulse = 1'b1;
                w_state_nxt  = S_DRAW;
            end
            S_DRAW: begin
                w_draw_req = 1'b1;
                if (draw_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Ticks that land while a sequence is in flight are dropped; count them, saturating.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overrun <= '0;
        end else if (r_frame_tick && (r_state != S_IDLE) && (r_overrun != 8'hFF)) begin
            r_overrun <= r_overrun + 8'd1;
        end
    end

    assign frame_tick  = r_frame_tick;
    assign erase_req   = w_erase_req;
    assign move_pulse  = w_move_pulse;
    assign draw_req    = w_draw_req;
    assign busy        = w_busy;
    assign level       = r_level;
    assign period      = r_period;
    assign overrun_cnt = r_overrun;

endmodule

// File: tb/tb_frame_scheduler.sv
module tb_frame_scheduler;

    logic        clk;
    logic        resetn;
    logic        enable;
    logic        level_up;
    logic        level_clr;
    logic        erase_done;
    logic        draw_done;
    logic        frame_tick;
    logic        erase_req;
    logic        move_pulse;
    logic        draw_req;
    logic        busy;
    logic [3:0]  level;
    logic [31:0] period;
    logic [7:0]  overrun_cnt;

    int checks   = 0;
    int failures = 0;

    frame_scheduler #(
        .CNT_W       (32),
        .BASE_PERIOD (9),
        .STEP        (2),
        .MIN_PERIOD  (3),
        .LEVEL_W     (4),
        .MAX_LEVEL   (15)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .level_up    (level_up),
        .level_clr   (level_clr),
        .erase_done  (erase_done),
        .draw_done   (draw_done),
        .frame_tick  (frame_tick),
        .erase_req   (erase_req),
        .move_pulse  (move_pulse),
        .draw_req    (draw_req),
        .busy        (busy),
        .level       (level),
        .period      (period),
        .overrun_cnt (overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then observed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count cycles until frame_tick is seen; -1 if the budget expires.
    task automatic wait_tick(input int max_cyc, output int n);
        int found;
        found = 0;
        for (int i = 1; i <= max_cyc && found == 0; i++) begin
            step();
            if (frame_tick === 1'b1) found = i;
        end
        n = (found == 0) ? -1 : found;
    endtask

    task automatic apply_reset();
        resetn     = 1'b0;
        enable     = 1'b0;
        level_up   = 1'b0;
        level_clr  = 1'b0;
        erase_done = 1'b0;
        draw_done  = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        resetn = 1'b0;
        #1;
        checks++; if (frame_tick !== 1'b0)   begin failures++; $display("FAIL rst_tick got=%0d exp=0", frame_tick); end
        checks++; if (erase_req !== 1'b0)    begin failures++; $display("FAIL rst_erase got=%0d exp=0", erase_req); end
        checks++; if (move_pulse !== 1'b0)   begin failures++; $display("FAIL rst_move got=%0d exp=0", move_pulse); end
        checks++; if (draw_req !== 1'b0)     begin failures++; $display("FAIL rst_draw got=%0d exp=0", draw_req); end
        checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL rst_busy got=%0d exp=0", busy); end
        checks++; if (level !== 4'd0)        begin failures++; $display("FAIL rst_level got=%0d exp=0", level); end
        checks++; if (period !== 32'd9)      begin failures++; $display("FAIL rst_period got=%0d exp=9", period); end
        checks++; if (overrun_cnt !== 8'd0)  begin failures++; $display("FAIL rst_overrun got=%0d exp=0", overrun_cnt); end
        resetn = 1'b1;
    endtask

    task automatic test_free_run();
        int n;
        apply_reset();
        erase_done = 1'b1;
        draw_done  = 1'b1;
        enable     = 1'b1;
        wait_tick(30, n);
        checks++; if (n !== 10) begin failures++; $display("FAIL fr_first_tick got=%0d exp=10", n); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL fr_tick_width got=%0d exp=0", frame_tick); end
            checks++; if ({erase_req, move_pulse, draw_req, busy} !== 4'b1001) begin failures++; $display("FAIL fr_erase got=%b exp=1001", {erase_req, move_pulse, draw_req, busy}); end
            step();
            checks++; if ({erase_req, move_pulse, draw_req, busy} !== 4'b0101) begin failures++; $display("FAIL fr_move got=%b exp=0101", {erase_req, move_pulse, draw_req, busy}); end
            step();
            checks++; if ({erase_req, move_pulse, draw_req, busy} !== 4'b0011) begin failures++; $display("FAIL fr_draw got=%b exp=0011", {erase_req, move_pulse, draw_req, busy}); end
            step();
            checks++; if ({erase_req, move_pulse, draw_req, busy} !== 4'b0000) begin failures++; $display("FAIL fr_idle got=%b exp=0000", {erase_req, move_pulse, draw_req, busy}); end
            wait_tick(30, n);
            checks++; if (n !== 6) begin failures++; $display("FAIL fr_spacing got=%0d exp=6", n); end
        end
    endtask

    task automatic test_handshake_stall();
        int n;
        apply_reset();
        enable = 1'b1;
        wait_tick(30, n);
        checks++; if (n !== 10) begin failures++; $display("FAIL hs_tick got=%0d exp=10", n); end
        // A draw_done during ERASE must be ignored.
        draw_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if ({erase_req, move_pulse, draw_req} !== 3'b100) begin failures++; $display("FAIL hs_erase_hold got=%b exp=100", {erase_req, move_pulse, draw_req}); end
        end
        draw_done  = 1'b0;
        erase_done = 1'b1;
        step();
        checks++; if ({erase_req, move_pulse, draw_req} !== 3'b010) begin failures++; $display("FAIL hs_move got=%b exp=010", {erase_req, move_pulse, draw_req}); end
        erase_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if ({erase_req, move_pulse, draw_req} !== 3'b001) begin failures++; $display("FAIL hs_draw_hold got=%b exp=001", {erase_req, move_pulse, draw_req}); end
        end
        draw_done = 1'b1;
        step();
        checks++; if ({draw_req, busy} !== 2'b00) begin failures++; $display("FAIL hs_done got=%b exp=00", {draw_req, busy}); end
        checks++; if (overrun_cnt !== 8'd0) begin failures++; $display("FAIL hs_overrun got=%0d exp=0", overrun_cnt); end
        erase_done = 1'b1;
    endtask

    task automatic test_level_clamp();
        int n;
        apply_reset();
        erase_done = 1'b1;
        draw_done  = 1'b1;
        enable     = 1'b1;
        level_up   = 1'b1;
        step();
        step();
        level_up = 1'b0;
        step();
        checks++; if (level !== 4'd2)   begin failures++; $display("FAIL lv_level2 got=%0d exp=2", level); end
        checks++; if (period !== 32'd5) begin failures++; $display("FAIL lv_period5 got=%0d exp=5", period); end
        // The count in progress still runs on the old reload of 9.
        wait_tick(30, n);
        checks++; if (n !== 7) begin failures++; $display("FAIL lv_inprog got=%0d exp=7", n); end
        wait_tick(30, n);
        checks++; if (n !== 6) begin failures++; $display("FAIL lv_spacing6 got=%0d exp=6", n); end
        level_up = 1'b1;
        repeat (3) step();
        level_up = 1'b0;
        step();
        checks++; if (level !== 4'd5)   begin failures++; $display("FAIL lv_level5 got=%0d exp=5", level); end
        checks++; if (period !== 32'd3) begin failures++; $display("FAIL lv_floor got=%0d exp=3", period); end
        wait_tick(30, n);
        checks++; if (n !== 2) begin failures++; $display("FAIL lv_reload got=%0d exp=2", n); end
        wait_tick(30, n);
        checks++; if (n !== 4) begin failures++; $display("FAIL lv_spacing4 got=%0d exp=4", n); end
        level_up = 1'b1;
        repeat (12) step();
        level_up = 1'b0;
        step();
        checks++; if (level !== 4'd15)  begin failures++; $display("FAIL lv_sat got=%0d exp=15", level); end
        checks++; if (period !== 32'd3) begin failures++; $display("FAIL lv_sat_period got=%0d exp=3", period); end
        level_up  = 1'b1;
        level_clr = 1'b1;
        step();
        level_up  = 1'b0;
        level_clr = 1'b0;
        checks++; if (level !== 4'd0) begin failures++; $display("FAIL lv_clr got=%0d exp=0", level); end
        step();
        checks++; if (period !== 32'd9) begin failures++; $display("FAIL lv_clr_period got=%0d exp=9", period); end
    endtask

    task automatic test_overrun();
        int n;
        apply_reset();
        draw_done = 1'b1;
        enable    = 1'b1;
        wait_tick(30, n);
        checks++; if (n !== 10) begin failures++; $display("FAIL ov_tick got=%0d exp=10", n); end
        repeat (35) step();
        checks++; if (overrun_cnt !== 8'd3) begin failures++; $display("FAIL ov_count got=%0d exp=3", overrun_cnt); end
        checks++; if (erase_req !== 1'b1)   begin failures++; $display("FAIL ov_stalled got=%0d exp=1", erase_req); end
        erase_done = 1'b1;
        repeat (3) step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ov_drain got=%0d exp=0", busy); end
        wait_tick(30, n);
        checks++; if (n !== 2) begin failures++; $display("FAIL ov_next_tick got=%0d exp=2", n); end
        step();
        checks++; if (erase_req !== 1'b1)   begin failures++; $display("FAIL ov_restart got=%0d exp=1", erase_req); end
        checks++; if (overrun_cnt !== 8'd3) begin failures++; $display("FAIL ov_idle_tick got=%0d exp=3", overrun_cnt); end

        // Long stall at minimum period: far more than 255 dropped ticks.
        apply_reset();
        level_up = 1'b1;
        repeat (15) step();
        level_up = 1'b0;
        step();
        step();
        draw_done = 1'b1;
        enable    = 1'b1;
        repeat (1100) step();
        checks++; if (overrun_cnt !== 8'd255) begin failures++; $display("FAIL ov_saturate got=%0d exp=255", overrun_cnt); end
        checks++; if (erase_req !== 1'b1)     begin failures++; $display("FAIL ov_sat_stalled got=%0d exp=1", erase_req); end
    endtask

    task automatic test_pause();
        int n;
        int seen;
        apply_reset();
        erase_done = 1'b1;
        draw_done  = 1'b1;
        enable     = 1'b1;
        wait_tick(30, n);
        checks++; if (n !== 10) begin failures++; $display("FAIL pz_tick got=%0d exp=10", n); end
        repeat (5) step();
        enable = 1'b0;
        seen   = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (frame_tick !== 1'b0) seen++;
        end
        checks++; if (seen !== 0)    begin failures++; $display("FAIL pz_no_tick got=%0d exp=0", seen); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL pz_idle got=%0d exp=0", busy); end
        enable = 1'b1;
        wait_tick(30, n);
        checks++; if (n !== 5) begin failures++; $display("FAIL pz_resume got=%0d exp=5", n); end
        draw_done = 1'b0;
        wait_tick(30, n);
        checks++; if (n !== 10) begin failures++; $display("FAIL pz_tick2 got=%0d exp=10", n); end
        repeat (3) step();
        checks++; if (draw_req !== 1'b1) begin failures++; $display("FAIL pz_in_draw got=%0d exp=1", draw_req); end
        enable = 1'b0;
        repeat (4) step();
        checks++; if ({draw_req, busy} !== 2'b11) begin failures++; $display("FAIL pz_draw_kept got=%b exp=11", {draw_req, busy}); end
        draw_done = 1'b1;
        step();
        checks++; if ({draw_req, busy} !== 2'b00) begin failures++; $display("FAIL pz_draw_done got=%b exp=00", {draw_req, busy}); end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (frame_tick !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL pz_stay_idle got=%0d exp=0", seen); end
    endtask

    task automatic test_reset_mid_draw();
        int n;
        apply_reset();
        erase_done = 1'b1;
        enable     = 1'b1;
        level_up   = 1'b1;
        step();
        level_up = 1'b0;
        wait_tick(30, n);
        checks++; if (n !== 9) begin failures++; $display("FAIL rd_tick got=%0d exp=9", n); end
        repeat (10) step();
        checks++; if (draw_req !== 1'b1)    begin failures++; $display("FAIL rd_in_draw got=%0d exp=1", draw_req); end
        checks++; if (overrun_cnt !== 8'd1) begin failures++; $display("FAIL rd_overrun got=%0d exp=1", overrun_cnt); end
        checks++; if (level !== 4'd1)       begin failures++; $display("FAIL rd_level got=%0d exp=1", level); end
        #3;
        resetn = 1'b0;
        #1;
        checks++; if ({erase_req, move_pulse, draw_req, busy, frame_tick} !== 5'b00000) begin failures++; $display("FAIL rd_outs got=%b exp=00000", {erase_req, move_pulse, draw_req, busy, frame_tick}); end
        checks++; if (level !== 4'd0)       begin failures++; $display("FAIL rd_level_clr got=%0d exp=0", level); end
        checks++; if (period !== 32'd9)     begin failures++; $display("FAIL rd_period got=%0d exp=9", period); end
        checks++; if (overrun_cnt !== 8'd0) begin failures++; $display("FAIL rd_overrun_clr got=%0d exp=0", overrun_cnt); end
        #2;
        resetn    = 1'b1;
        draw_done = 1'b1;
        wait_tick(30, n);
        checks++; if (n !== 10) begin failures++; $display("FAIL rd_first_tick got=%0d exp=10", n); end
    endtask

    initial begin
        resetn     = 1'b0;
        enable     = 1'b0;
        level_up   = 1'b0;
        level_clr  = 1'b0;
        erase_done = 1'b0;
        draw_done  = 1'b0;
        test_reset();
        test_free_run();
        test_handshake_stall();
        test_level_clamp();
        test_overrun();
        test_pause();
        test_reset_mid_draw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
